// File: rtl/ebi_pkg.sv
// rtl/ebi_pkg.sv - shared lane constants and credit encoding for the EBI message path
package ebi_pkg;

  localparam int M1_M2_CHANNEL_NUM         = 5;
  localparam int M1_M2_CHANNEL_NUM_WIDTH   = 3;
  localparam int MAX_M1_M2_MESSAGE_LENGTH  = 20;
  localparam int PARITY_LENGTH             = 8;
  localparam int M1_M2_CHANNEL_LENGTH_LIST [M1_M2_CHANNEL_NUM] = '{12, 16, 8, 4, 20};

  typedef enum logic [1:0] {
    NO_CREDIT = 2'd0,
    SUCCESS   = 2'd1,
    FAILURE   = 2'd2
  } credit_t;

  localparam int CREDIT_WIDTH = $bits(credit_t);

endpackage

// File: rtl/ebi_msg_receiver.sv
// rtl/ebi_msg_receiver.sv - serial VC frame decoder with grouped even parity and credit return
module ebi_msg_receiver #(
  parameter int CH_NUM                = ebi_pkg::M1_M2_CHANNEL_NUM,
  parameter int CH_ID_WIDTH           = ebi_pkg::M1_M2_CHANNEL_NUM_WIDTH,
  parameter int MAX_MSG_LEN           = ebi_pkg::MAX_M1_M2_MESSAGE_LENGTH,
  parameter int CH_LEN_LIST [CH_NUM]  = ebi_pkg::M1_M2_CHANNEL_LENGTH_LIST,
  parameter int PARITY_LEN            = ebi_pkg::PARITY_LENGTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_data_i,
  input  logic [CH_NUM-1:0]                 vc_full_i,
  output logic                              msg_valid_o,
  output logic [CH_ID_WIDTH-1:0]            msg_vc_id_o,
  output logic [MAX_MSG_LEN-1:0]            msg_data_o,
  output logic                              credit_valid_o,
  output logic [ebi_pkg::CREDIT_WIDTH-1:0]  credit_o,
  input  logic                              credit_ready_i
);

  localparam int CNT_W = $clog2(MAX_MSG_LEN + 1);
  localparam int GRP_W = $clog2(PARITY_LEN + 1);
  localparam int IDC_W = $clog2(CH_ID_WIDTH + 1);

  typedef enum logic [1:0] {
    RECV_IDLE,
    GET_VC_NUM,
    RECV_MESSSAGE,
    MAKE_CREDIT
  } recv_state_t;

  recv_state_t            state;
  logic [IDC_W-1:0]       id_cnt;
  logic [CH_ID_WIDTH-1:0] vc_id;
  logic [CNT_W-1:0]       pay_cnt;
  logic [GRP_W-1:0]       grp_cnt;
  logic                   grp_par;
  logic                   par_err;
  logic [MAX_MSG_LEN-1:0] msg_buf;

  logic [CNT_W-1:0]       cur_len;
  logic                   id_valid;
  logic                   cur_full;
  logic                   par_slot;
  logic                   end_slot;
  logic                   frame_ok;

  // Unknown ids still consume a full-length frame so the lane stays aligned.
  always_comb begin
    cur_len  = CNT_W'(MAX_MSG_LEN);
    id_valid = 1'b0;
    cur_full = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (vc_id == CH_ID_WIDTH'(i)) begin
        cur_len  = CNT_W'(CH_LEN_LIST[i]);
        id_valid = 1'b1;
        cur_full = vc_full_i[i];
      end
    end
    par_slot = (grp_cnt == GRP_W'(PARITY_LEN)) || ((pay_cnt == cur_len) && (grp_cnt != '0));
    end_slot = (pay_cnt == cur_len) && (grp_cnt == '0);
    frame_ok = !par_err && rx_data_i && id_valid && !cur_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RECV_IDLE;
      id_cnt         <= '0;
      vc_id          <= '0;
      pay_cnt        <= '0;
      grp_cnt        <= '0;
      grp_par        <= 1'b0;
      par_err        <= 1'b0;
      msg_buf        <= '0;
      msg_valid_o    <= 1'b0;
      msg_vc_id_o    <= '0;
      msg_data_o     <= '0;
      credit_valid_o <= 1'b0;
      credit_o       <= ebi_pkg::NO_CREDIT;
    end else begin
      msg_valid_o <= 1'b0;
      case (state)
        RECV_IDLE: begin
          if (rx_data_i) begin
            state   <= GET_VC_NUM;
            id_cnt  <= '0;
            vc_id   <= '0;
            pay_cnt <= '0;
            grp_cnt <= '0;
            grp_par <= 1'b0;
            par_err <= 1'b0;
            msg_buf <= '0;
          end
        end
        GET_VC_NUM: begin
          vc_id[id_cnt] <= rx_data_i;
          id_cnt        <= id_cnt + 1'b1;
          if (id_cnt == IDC_W'(CH_ID_WIDTH - 1)) state <= RECV_MESSSAGE;
        end
        RECV_MESSSAGE: begin
          if (par_slot) begin
            if (rx_data_i != grp_par) par_err <= 1'b1;
            grp_cnt <= '0;
            grp_par <= 1'b0;
          end else if (end_slot) begin
            state          <= MAKE_CREDIT;
            credit_valid_o <= 1'b1;
            credit_o       <= frame_ok ? ebi_pkg::SUCCESS : ebi_pkg::FAILURE;
            if (frame_ok) begin
              msg_valid_o <= 1'b1;
              msg_vc_id_o <= vc_id;
              msg_data_o  <= msg_buf;
            end
          end else begin
            msg_buf[pay_cnt] <= rx_data_i;
            pay_cnt          <= pay_cnt + 1'b1;
            grp_cnt          <= grp_cnt + 1'b1;
            grp_par          <= grp_par ^ rx_data_i;
          end
        end
        MAKE_CREDIT: begin
          // The lane is deaf here; the sender must not start a frame before the credit returns.
          if (credit_ready_i) begin
            state          <= RECV_IDLE;
            credit_valid_o <= 1'b0;
            credit_o       <= ebi_pkg::NO_CREDIT;
          end
        end
        default: state <= RECV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ebi_msg_receiver.sv
// tb/tb_ebi_msg_receiver.sv - directed self-checking bench for ebi_msg_receiver
module tb_ebi_msg_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_data;
  logic [4:0]  vc_full;
  logic        msg_valid;
  logic [2:0]  msg_vc_id;
  logic [19:0] msg_data;
  logic        credit_valid;
  logic [1:0]  credit;
  logic        credit_ready;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int credit_seen = 0;

  localparam int LEN_LIST [5] = '{12, 16, 8, 4, 20};

  ebi_msg_receiver #(
    .CH_NUM      (5),
    .CH_ID_WIDTH (3),
    .MAX_MSG_LEN (20),
    .CH_LEN_LIST (LEN_LIST),
    .PARITY_LEN  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data_i      (rx_data),
    .vc_full_i      (vc_full),
    .msg_valid_o    (msg_valid),
    .msg_vc_id_o    (msg_vc_id),
    .msg_data_o     (msg_data),
    .credit_valid_o (credit_valid),
    .credit_o       (credit),
    .credit_ready_i (credit_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (msg_valid) pulse_cnt <= pulse_cnt + 1;
    if (credit_valid) credit_seen <= credit_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int id, input logic [19:0] pay, input int len,
                            input bit bad_par, input logic end_bit);
    logic [31:0] idv;
    logic        par;
    int          g;
    bit          flipped;
    idv = id;
    par = 1'b0;
    g = 0;
    flipped = 1'b0;
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_bit(idv[i]);
    for (int k = 0; k < len; k++) begin
      send_bit(pay[k]);
      par = par ^ pay[k];
      g++;
      if (g == 8 || k == len - 1) begin
        send_bit(par ^ (bad_par && !flipped));
        flipped = flipped | bad_par;
        par = 1'b0;
        g = 0;
      end
    end
    send_bit(end_bit);
    rx_data = 1'b0;
  endtask

  // Called #1 after the end-bit edge; holds ready low for 'hold' cycles, then handshakes.
  task automatic close_frame(input string tag, input logic [1:0] exp_credit, input logic exp_valid,
                             input logic [2:0] exp_id, input logic [19:0] exp_data,
                             input int hold, input logic rx_during_hold);
    check({tag, "_cvalid"}, credit_valid, 1);
    check({tag, "_credit"}, credit, exp_credit);
    check({tag, "_mvalid"}, msg_valid, exp_valid);
    check({tag, "_id"}, msg_vc_id, exp_id);
    check({tag, "_data"}, msg_data, exp_data);
    for (int c = 0; c < hold; c++) begin
      rx_data = rx_during_hold;
      @(posedge clk);
      #1;
      check({tag, "_hold_cvalid"}, credit_valid, 1);
      check({tag, "_hold_credit"}, credit, exp_credit);
      check({tag, "_hold_mvalid"}, msg_valid, 0);
      check({tag, "_hold_data"}, msg_data, exp_data);
    end
    credit_ready = 1'b1;
    @(posedge clk);
    #1;
    credit_ready = 1'b0;
    rx_data = 1'b0;
    check({tag, "_done_cvalid"}, credit_valid, 0);
    check({tag, "_done_credit"}, credit, 2'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx_data = 1'b0;
    vc_full = '0;
    credit_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mvalid", msg_valid, 0);
    check("rst_id", msg_vc_id, 0);
    check("rst_data", msg_data, 0);
    check("rst_cvalid", credit_valid, 0);
    check("rst_credit", credit, 2'd0);
    rst = 1'b0;
    send_bit(1'b0);

    send_frame(0, 20'h00A5C, 12, 1'b0, 1'b1);
    close_frame("vc0_ok", 2'd1, 1'b1, 3'd0, 20'h00A5C, 2, 1'b0);

    send_frame(2, 20'h000FF, 8, 1'b1, 1'b1);
    close_frame("vc2_par", 2'd2, 1'b0, 3'd0, 20'h00A5C, 1, 1'b0);

    send_frame(3, 20'h00009, 4, 1'b0, 1'b0);
    close_frame("vc3_end0", 2'd2, 1'b0, 3'd0, 20'h00A5C, 0, 1'b0);
    send_frame(3, 20'h00006, 4, 1'b0, 1'b1);
    close_frame("vc3_ok", 2'd1, 1'b1, 3'd3, 20'h00006, 0, 1'b0);

    vc_full = 5'b00010;
    send_frame(1, 20'h0BEEF, 16, 1'b0, 1'b1);
    close_frame("vc1_full", 2'd2, 1'b0, 3'd3, 20'h00006, 0, 1'b0);
    vc_full = '0;

    send_frame(7, 20'hABCDE, 20, 1'b0, 1'b1);
    close_frame("id7", 2'd2, 1'b0, 3'd3, 20'h00006, 0, 1'b0);

    send_frame(4, 20'hF0F0F, 20, 1'b0, 1'b1);
    close_frame("vc4_max", 2'd1, 1'b1, 3'd4, 20'hF0F0F, 5, 1'b1);

    send_frame(1, 20'h01234, 16, 1'b0, 1'b1);
    close_frame("vc1_after_hold", 2'd1, 1'b1, 3'd1, 20'h01234, 0, 1'b0);

    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    for (int k = 0; k < 5; k++) send_bit(1'b1);
    rst = 1'b1;
    rx_data = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_mvalid", msg_valid, 0);
    check("midrst_id", msg_vc_id, 0);
    check("midrst_data", msg_data, 0);
    check("midrst_cvalid", credit_valid, 0);
    check("midrst_credit", credit, 2'd0);
    credit_seen = 0;
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_credit", credit_seen, 0);

    send_frame(3, 20'h0000A, 4, 1'b0, 1'b1);
    close_frame("vc3_post_rst", 2'd1, 1'b1, 3'd3, 20'h0000A, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("pulse_total", pulse_cnt, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ebi_msg_receiver.md
EBI_MSG_RECEIVER -- requirements
Module: ebi_msg_receiver

Interface
REQ-001 SHALL have parameter CH_NUM, default ebi_pkg::M1_M2_CHANNEL_NUM, number of virtual channels (VCs) on the lane.
REQ-002 SHALL have parameter CH_ID_WIDTH, default ebi_pkg::M1_M2_CHANNEL_NUM_WIDTH, width of the serial VC-id field.
REQ-003 SHALL have parameter MAX_MSG_LEN, default ebi_pkg::MAX_M1_M2_MESSAGE_LENGTH, width of the message output.
REQ-004 SHALL have parameter CH_LEN_LIST[CH_NUM], default ebi_pkg::M1_M2_CHANNEL_LENGTH_LIST, payload bits per VC, each 1..MAX_MSG_LEN.
REQ-005 SHALL have parameter PARITY_LEN, default ebi_pkg::PARITY_LENGTH, payload bits per parity group.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port rx_data_i, input, 1, serial lane, one bit sampled per clk.
REQ-009 SHALL have port vc_full_i, input, CH_NUM, per-VC buffer full flag.
REQ-010 SHALL have port msg_valid_o, output, 1, one-cycle message-delivered strobe.
REQ-011 SHALL have port msg_vc_id_o, output, CH_ID_WIDTH, VC id of the delivered message.
REQ-012 SHALL have port msg_data_o, output, MAX_MSG_LEN, delivered payload.
REQ-013 SHALL have port credit_valid_o, output, 1, credit available to the credit sender.
REQ-014 SHALL have port credit_o, output, CREDIT_WIDTH, ebi_pkg::credit_t value.
REQ-015 SHALL have port credit_ready_i, input, 1, credit sender accepts credit.

Function
REQ-016 SHALL decode this frame format: idle 0; start bit 1; CH_ID_WIDTH id bits, LSB first; L payload bits, LSB first, where L=CH_LEN_LIST[id]; after every PARITY_LEN payload bits, and after a final partial group, one even-parity bit equal to the XOR of that group; end bit 1.
REQ-017 SHALL implement an FSM of type recv_state_t: RECV_IDLE -> GET_VC_NUM when a 1 is sampled; GET_VC_NUM -> RECV_MESSSAGE after CH_ID_WIDTH bits; RECV_MESSSAGE -> MAKE_CREDIT after L payload bits, ceil(L/PARITY_LEN) parity bits and the end bit have been sampled; MAKE_CREDIT -> RECV_IDLE on credit_valid_o && credit_ready_i.
REQ-018 SHALL use a payload counter and a group counter; a group counter value of PARITY_LEN, or a payload count of L, makes the next sampled bit a parity bit, never a data bit.
REQ-019 SHALL write payload bit k to internal msg bit k; bits k>=L SHALL be 0 on msg_data_o.
REQ-020 SHALL, for an id >= CH_NUM, use L=MAX_MSG_LEN and force the result to FAILURE.
REQ-021 SHALL set the result to SUCCESS only if all parity bits match, the end bit is 1, the id is valid, and vc_full_i[id] is 0 when the end bit is sampled; otherwise the result SHALL be FAILURE.
REQ-022 SHALL, on entry to MAKE_CREDIT (one cycle after the end bit is sampled), pulse msg_valid_o for exactly one cycle with msg_vc_id_o/msg_data_o, only on SUCCESS.
REQ-023 SHALL assert credit_valid_o from entry to MAKE_CREDIT, and hold it and credit_o stable until credit_ready_i; credit_o SHALL be NO_CREDIT whenever credit_valid_o is 0.
REQ-024 SHALL ignore rx_data_i while in MAKE_CREDIT; a frame starts only from RECV_IDLE.
REQ-025 SHALL treat credit_valid_o and credit_ready_i high in the same cycle as a handshake completed that cycle, and SHALL be in RECV_IDLE on the next cycle.
REQ-026 SHALL hold msg_data_o and msg_vc_id_o stable at their last values while msg_valid_o is 0.

Reset
REQ-027 SHALL, while rst is high at a clk edge, go to RECV_IDLE, clear counters, parity and error flags, and drive msg_valid_o=0, msg_vc_id_o=0, msg_data_o=0, credit_valid_o=0, credit_o=NO_CREDIT.
REQ-028 SHALL, on reset mid-frame, discard the partial frame without any msg_valid_o pulse or credit.

Verification
REQ-029 SHALL be verified with CH_LEN_LIST='{12,16,8,4,20}, MAX_MSG_LEN=20, PARITY_LEN=8, CH_ID_WIDTH=3 for the following scenarios.
REQ-030 Scenario: VC0 payload 0xA5C with correct parities, end=1, vc_full_i=0 -> msg_valid_o for 1 cycle, id 0, data 0x00A5C; credit SUCCESS held until ready.
REQ-031 Scenario: VC2 payload 0xFF with the parity bit flipped -> no msg_valid_o; credit FAILURE.
REQ-032 Scenario: VC3 frame with end bit 0 -> FAILURE; next frame accepted normally after the handshake.
REQ-033 Scenario: VC1 frame valid but vc_full_i[1]=1 at the end bit -> FAILURE, no msg_valid_o.
REQ-034 Scenario: id 7 followed by 20 payload bits and 3 parity bits -> FAILURE.
REQ-035 Scenario: credit_ready_i held low for 5 cycles with start bits on rx_data_i -> those bits are ignored and credit is held; rst pulsed mid-payload -> RECV_IDLE with all outputs reset.
